// File: rtl/hweval_resp_misr_pkg.sv
// Shared types, constants and the MISR step function for the response
// compactor. The step function is also available to golden models.
package hweval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CAPTURE,
    DONE
  } hweval_resp_state_t;

  localparam logic [31:0] HWEVAL_MISR_POLY = 32'h04C1_1DB7;

  // Widest signature the step function can handle
  localparam int HWEVAL_MISR_MAX_W = 64;

  // One MISR step on a width-bit register held in the low bits of a 64-bit
  // word: shift left, fold the polynomial in when the MSB falls out, then
  // xor the (already zero-extended) input word.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] din,
                                            input logic [63:0] poly,
                                            input int          width = 32);
    logic [63:0] mask;
    logic [63:0] shifted;
    logic        msb;
    mask      = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    msb       = sig[6'(width - 1)];
    shifted   = (sig << 1) & mask;
    misr_next = (shifted ^ (msb ? poly : 64'h0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/hweval_resp_misr_misr_reg.sv
// Multiple-input signature register: loads a seed or folds one input word
// per enabled cycle. Kept separate so multi-output DUTs can use several.
module misr_reg
  import hweval_pkg::*;
#(
  parameter int                   SIG_WIDTH = 32,
  parameter int                   IN_WIDTH  = 10,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(HWEVAL_MISR_POLY)
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [SIG_WIDTH-1:0] seed,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [SIG_WIDTH-1:0] sig
);

  if (SIG_WIDTH > HWEVAL_MISR_MAX_W) begin : g_sig_too_wide
    $error("misr_reg: SIG_WIDTH exceeds the supported maximum of 64");
  end

  if (SIG_WIDTH < IN_WIDTH) begin : g_sig_too_narrow
    $error("misr_reg: SIG_WIDTH must be >= IN_WIDTH");
  end

  // Load has priority so a reset or restart always wins over compaction
  always_ff @(posedge clk) begin
    if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= SIG_WIDTH'(misr_next(64'(sig), 64'(din), 64'(POLY), SIG_WIDTH));
    end
  end

endmodule

// File: rtl/hweval_resp_misr.sv
// Response compactor for hardware-eval wrappers: discards the DUT pipeline
// fill, then folds a programmed number of responses into one signature.
module hweval_resp_misr
  import hweval_pkg::*;
#(
  parameter int          IN_WIDTH  = 10,
  parameter int          SIG_WIDTH = 32,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] POLY      = HWEVAL_MISR_POLY,
  parameter logic [31:0] SEED      = 32'h0000_0000,
  parameter int          PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_cycles,
  input  logic [IN_WIDTH-1:0]  resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_WIDTH-1:0] cycles_done
);

  if (SIG_WIDTH < IN_WIDTH) begin : g_bad_width
    $error("hweval_resp_misr: SIG_WIDTH must be >= IN_WIDTH");
  end

  localparam logic [SIG_WIDTH-1:0] POLY_W     = SIG_WIDTH'(POLY);
  localparam logic [SIG_WIDTH-1:0] SEED_W     = SIG_WIDTH'(SEED);
  localparam int                   FLUSH_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  hweval_resp_state_t   state;
  logic [CNT_WIDTH-1:0] n_req;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 start_accept;
  logic                 misr_load;
  logic                 misr_en;

  assign start_accept = start && ((state == IDLE) || (state == DONE));
  assign cnt_inc      = cycles_done + CNT_WIDTH'(1);
  assign misr_load    = reset || start_accept;
  assign misr_en      = (state == CAPTURE);

  misr_reg #(
    .SIG_WIDTH(SIG_WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .POLY     (POLY_W)
  ) u_misr (
    .clk (clk),
    .load(misr_load),
    .seed(SEED_W),
    .en  (misr_en),
    .din (resp_in),
    .sig (signature)
  );

  // Run sequencing: done is registered from the DONE state so it trails the
  // last compaction by one cycle; a zero-length restart from DONE keeps it up
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycles_done <= '0;
      n_req       <= '0;
      flush_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_accept) begin
            cycles_done <= '0;
            n_req       <= num_cycles;
            flush_cnt   <= '0;
            if (PIPE_LAT > 0) begin
              state <= FLUSH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else if (num_cycles != '0) begin
              state <= CAPTURE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= (state == DONE);
            end
          end else begin
            busy <= 1'b0;
            done <= (state == DONE);
          end
        end
        FLUSH: begin
          done <= 1'b0;
          if (flush_cnt == FLUSH_LAST) begin
            if (n_req != '0) begin
              state <= CAPTURE;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        CAPTURE: begin
          done        <= 1'b0;
          cycles_done <= cnt_inc;
          if (cnt_inc == n_req) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hweval_resp_misr.sv
// Bench for the response MISR: three instances (default, zero pipeline
// latency, and MSB-set seed) driven by per-scenario tasks with a scoreboard.
module tb_hweval_resp_misr;

  localparam logic [31:0] POLY_C  = 32'h04C1_1DB7;
  localparam logic [31:0] SEED_S  = 32'h8000_0000;
  localparam int          BOUND   = 400;

  typedef struct {
    logic [31:0] sig;
    logic [15:0] cd;
    int          lat;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [2:0]       start_v;
  logic [15:0]      num_cycles;
  logic [9:0]       resp_in;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0][31:0] sig_v;
  logic [2:0][15:0] cd_v;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  logic [9:0] resp_q[$];

  hweval_resp_misr dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .num_cycles(num_cycles),
    .resp_in(resp_in), .busy(busy_v[0]), .done(done_v[0]),
    .signature(sig_v[0]), .cycles_done(cd_v[0])
  );

  hweval_resp_misr #(.PIPE_LAT(0)) dut_p0 (
    .clk(clk), .reset(reset), .start(start_v[1]), .num_cycles(num_cycles),
    .resp_in(resp_in), .busy(busy_v[1]), .done(done_v[1]),
    .signature(sig_v[1]), .cycles_done(cd_v[1])
  );

  hweval_resp_misr #(.PIPE_LAT(0), .SEED(SEED_S)) dut_s (
    .clk(clk), .reset(reset), .start(start_v[2]), .num_cycles(num_cycles),
    .resp_in(resp_in), .busy(busy_v[2]), .done(done_v[2]),
    .signature(sig_v[2]), .cycles_done(cd_v[2])
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent golden model: folds resp_q[p .. p+n-1] starting from seed
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int p, input int n);
    logic [31:0] s;
    logic [9:0]  d;
    s = seed;
    for (int i = 0; i < n; i++) begin
      d = (p + i < resp_q.size()) ? resp_q[p + i] : 10'h0;
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY_C : 32'h0) ^ {22'h0, d};
    end
    return s;
  endfunction

  function automatic void fill_random(input int count);
    resp_q.delete();
    for (int i = 0; i < count; i++) resp_q.push_back(10'($urandom));
  endfunction

  // Pulses start on one instance, streams resp_q one word per edge from the
  // edge after start, and returns the edge count until done (or the bound).
  task automatic run(input int inst, input int n, input int restart_at,
                     input int reset_at, output int lat);
    num_cycles    = 16'(n);
    start_v[inst] = 1'b1;
    tick();
    start_v[inst] = 1'b0;
    lat = 0;
    while (lat < BOUND) begin
      resp_in = (resp_q.size() > 0) ? resp_q.pop_front() : 10'h0;
      if (lat == restart_at) begin
        start_v[inst] = 1'b1;
        num_cycles    = 16'd5;
      end
      if (lat == reset_at) reset = 1'b1;
      tick();
      lat++;
      start_v[inst] = 1'b0;
      if (reset_at >= 0 && lat == reset_at + 1) begin
        reset = 1'b0;
        resp_q.delete();
        return;
      end
      if (done_v[inst]) break;
    end
    resp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] seeds [3];
    seeds = '{32'h0, 32'h0, SEED_S};
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors += 4;
      if (busy_v[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", i, busy_v[i]);
      end
      if (done_v[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_done[%0d]: got %b expected 0", i, done_v[i]);
      end
      if (sig_v[i] !== seeds[i]) begin
        miscompares++;
        $display("[TB] FAIL reset_sig[%0d]: got %h expected %h", i, sig_v[i], seeds[i]);
      end
      if (cd_v[i] !== 16'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_cnt[%0d]: got %0d expected 0", i, cd_v[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  // Runs one scenario and compares latency, signature, count and busy
  // against the scoreboard head; each scenario task owns its comparisons.
  task automatic test_single_capture();
    int   lat;
    exp_t e;
    resp_q = '{10'h3FF};
    exp_q.push_back('{32'h0000_03FF, 16'd1, 2});
    run(1, 1, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL single_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[1] !== e.sig) begin
      miscompares++; $display("[TB] FAIL single_sig: got %h expected %h", sig_v[1], e.sig);
    end
    if (cd_v[1] !== e.cd) begin
      miscompares++; $display("[TB] FAIL single_cnt: got %0d expected %0d", cd_v[1], e.cd);
    end
  endtask

  task automatic test_no_feedback();
    int   lat;
    exp_t e;
    resp_q = '{10'h001, 10'h002};
    exp_q.push_back('{32'h0000_0000, 16'd2, 3});
    run(1, 2, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL nofb_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[1] !== e.sig) begin
      miscompares++; $display("[TB] FAIL nofb_sig: got %h expected %h", sig_v[1], e.sig);
    end
    if (cd_v[1] !== e.cd) begin
      miscompares++; $display("[TB] FAIL nofb_cnt: got %0d expected %0d", cd_v[1], e.cd);
    end
  endtask

  task automatic test_msb_feedback();
    int   lat;
    exp_t e;
    resp_q = '{10'h000};
    exp_q.push_back('{32'h04C1_1DB7, 16'd1, 2});
    run(2, 1, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL msbfb_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[2] !== e.sig) begin
      miscompares++; $display("[TB] FAIL msbfb_sig: got %h expected %h", sig_v[2], e.sig);
    end
    if (cd_v[2] !== e.cd) begin
      miscompares++; $display("[TB] FAIL msbfb_cnt: got %0d expected %0d", cd_v[2], e.cd);
    end
  endtask

  task automatic test_flush_discard();
    int   lat;
    exp_t e;
    resp_q = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
    exp_q.push_back('{model_sig(32'h0, 2, 3), 16'd3, 6});
    run(0, 3, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 4;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL flush_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[0] !== e.sig) begin
      miscompares++; $display("[TB] FAIL flush_sig: got %h expected %h", sig_v[0], e.sig);
    end
    if (cd_v[0] !== e.cd) begin
      miscompares++; $display("[TB] FAIL flush_cnt: got %0d expected %0d", cd_v[0], e.cd);
    end
    if (busy_v[0] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_busy: got %b expected 0", busy_v[0]);
    end
  endtask

  task automatic test_zero_cycles();
    int   lat;
    exp_t e;
    resp_q.delete();
    exp_q.push_back('{32'h0, 16'd0, 1});
    run(1, 0, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL zero_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[1] !== e.sig) begin
      miscompares++; $display("[TB] FAIL zero_sig: got %h expected %h", sig_v[1], e.sig);
    end
    if (cd_v[1] !== e.cd) begin
      miscompares++; $display("[TB] FAIL zero_cnt: got %0d expected %0d", cd_v[1], e.cd);
    end
  endtask

  task automatic test_ignored_start();
    int   lat;
    exp_t e;
    fill_random(102);
    exp_q.push_back('{model_sig(32'h0, 2, 100), 16'd100, 103});
    run(0, 100, 10, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL ignstart_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[0] !== e.sig) begin
      miscompares++; $display("[TB] FAIL ignstart_sig: got %h expected %h", sig_v[0], e.sig);
    end
    if (cd_v[0] !== e.cd) begin
      miscompares++; $display("[TB] FAIL ignstart_cnt: got %0d expected %0d", cd_v[0], e.cd);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    int   lens [2];
    lens = '{4, 7};
    for (int k = 0; k < 2; k++) begin
      fill_random(lens[k]);
      exp_q.push_back('{model_sig(SEED_S, 0, lens[k]), 16'(lens[k]), lens[k] + 1});
      run(2, lens[k], -1, -1, lat);
      e = exp_q.pop_front();
      vectors += 3;
      if (lat !== e.lat) begin
        miscompares++; $display("[TB] FAIL b2b_lat[%0d]: got %0d expected %0d", k, lat, e.lat);
      end
      if (sig_v[2] !== e.sig) begin
        miscompares++; $display("[TB] FAIL b2b_sig[%0d]: got %h expected %h", k, sig_v[2], e.sig);
      end
      if (cd_v[2] !== e.cd) begin
        miscompares++; $display("[TB] FAIL b2b_cnt[%0d]: got %0d expected %0d", k, cd_v[2], e.cd);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    exp_t e;
    fill_random(102);
    run(0, 100, -1, 50, lat);
    vectors += 4;
    if (busy_v[0] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_v[0]);
    end
    if (done_v[0] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_done: got %b expected 0", done_v[0]);
    end
    if (sig_v[0] !== 32'h0) begin
      miscompares++; $display("[TB] FAIL abort_sig: got %h expected 00000000", sig_v[0]);
    end
    if (cd_v[0] !== 16'h0) begin
      miscompares++; $display("[TB] FAIL abort_cnt: got %0d expected 0", cd_v[0]);
    end
    tick();
    fill_random(102);
    exp_q.push_back('{model_sig(32'h0, 2, 100), 16'd100, 103});
    run(0, 100, -1, -1, lat);
    e = exp_q.pop_front();
    vectors += 3;
    if (lat !== e.lat) begin
      miscompares++; $display("[TB] FAIL rerun_lat: got %0d expected %0d", lat, e.lat);
    end
    if (sig_v[0] !== e.sig) begin
      miscompares++; $display("[TB] FAIL rerun_sig: got %h expected %h", sig_v[0], e.sig);
    end
    if (cd_v[0] !== e.cd) begin
      miscompares++; $display("[TB] FAIL rerun_cnt: got %0d expected %0d", cd_v[0], e.cd);
    end
  endtask

  // Scenario sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start_v     = 3'b000;
    num_cycles  = 16'h0;
    resp_in     = 10'h0;
    test_reset();
    test_single_capture();
    test_no_feedback();
    test_msb_feedback();
    test_flush_discard();
    test_zero_cycles();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
